// File: rtl/morse_pkg.sv
// Shared symbol codes, unit multiples and FSM state type for the Morse keyer
// and the future receive-side decoder.
package morse_pkg;

  localparam logic [1:0] SYM_END  = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_WSP  = 2'b11;

  localparam logic [2:0] DOT_U  = 3'd1;
  localparam logic [2:0] DASH_U = 3'd3;
  localparam logic [2:0] GAP_U  = 3'd1;
  localparam logic [2:0] CGAP_U = 3'd2;
  localparam logic [2:0] WSP_U  = 3'd7;

  localparam int SYMS_PER_WORD = 10;
  localparam int WORD_W        = 2 * SYMS_PER_WORD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_MARK,
    ST_GAP,
    ST_WSPACE,
    ST_CGAP,
    ST_ACK,
    ST_SETTLE
  } state_t;

endpackage

// File: rtl/morse_keyer_if.sv
// Character FIFO read port: head word, non-empty flag and the advance pulse.
interface morse_keyer_if;
  import morse_pkg::*;

  logic [WORD_W-1:0] i_data;
  logic              i_valid;
  logic              o_next;

  modport master (output i_data, output i_valid, input o_next);
  modport slave  (input i_data, input i_valid, output o_next);

endinterface

// File: rtl/morse_unit_timer.sv
// Down-counting interval timer: load n units, expire on the cycle the count is 0.
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 1200000,
  parameter int CNT_W       = 24
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [2:0] i_units,
  output logic       o_expired
);

  localparam logic [CNT_W-1:0] UNIT_C = CNT_W'(UNIT_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic [CNT_W-1:0] w_load_val;

  assign w_load_val = CNT_W'(i_units) * UNIT_C - CNT_W'(1);
  assign o_expired  = r_run && (r_cnt == '0);

  // A load on the expiry cycle wins, so intervals chain with no dead cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_load) begin
      r_cnt <= w_load_val;
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == '0) r_run <= 1'b0;
      else             r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/morse_keyer.sv
// Reads one encoded character from the FIFO head, keys it out on o_key, then
// pulses o_next. States: IDLE wait | FETCH decode | MARK tone | GAP symbol gap |
// WSPACE word space | CGAP char gap tail | ACK o_next | SETTLE FIFO holdoff.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 1200000,
  parameter int CNT_W       = 24
) (
  input  logic                i_clk,
  input  logic                i_rst,
  morse_keyer_if.slave        fifo,
  output logic                o_key,
  output logic                o_busy
);

  localparam logic [3:0] IDX_MAX = 4'(SYMS_PER_WORD);

  state_t            r_state;
  logic [WORD_W-1:0] r_shift;
  logic [3:0]        r_idx;
  logic              r_ws_last;
  logic              r_key;
  logic              r_next;
  logic              r_busy;

  logic       w_expired;
  logic       w_load;
  logic [2:0] w_units;
  logic [1:0] w_sym;
  logic       w_end;

  assign w_sym = r_shift[WORD_W-1 -: 2];
  assign w_end = (r_idx == IDX_MAX) || (w_sym == SYM_END);

  assign o_key       = r_key;
  assign o_busy      = r_busy;
  assign fifo.o_next = r_next;

  // Timer must load on the same edge the FSM enters the timed state.
  always_comb begin
    w_load  = 1'b0;
    w_units = GAP_U;
    case (r_state)
      ST_FETCH: begin
        w_load = !(w_end && r_ws_last);
        if (w_end)                   w_units = CGAP_U;
        else if (w_sym == SYM_DOT)   w_units = DOT_U;
        else if (w_sym == SYM_DASH)  w_units = DASH_U;
        else                         w_units = WSP_U;
      end
      ST_MARK: begin
        w_load  = w_expired;
        w_units = GAP_U;
      end
      default: ;
    endcase
  end

  morse_unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_load),
    .i_units   (w_units),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_idx     <= '0;
      r_ws_last <= 1'b0;
      r_key     <= 1'b0;
      r_next    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_next <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (fifo.i_valid) begin
            r_busy <= 1'b1;
            if (fifo.i_data != '0) begin
              r_shift   <= fifo.i_data;
              r_idx     <= '0;
              r_ws_last <= 1'b0;
              r_state   <= ST_FETCH;
            end else begin
              r_next  <= 1'b1;
              r_state <= ST_ACK;
            end
          end
        end
        ST_FETCH: begin
          if (w_end) begin
            if (r_ws_last) begin
              r_next  <= 1'b1;
              r_state <= ST_ACK;
            end else begin
              r_state <= ST_CGAP;
            end
          end else if (w_sym == SYM_WSP) begin
            r_state <= ST_WSPACE;
          end else begin
            r_key   <= 1'b1;
            r_state <= ST_MARK;
          end
        end
        ST_MARK: begin
          if (w_expired) begin
            r_key     <= 1'b0;
            r_shift   <= {r_shift[WORD_W-3:0], 2'b00};
            if (r_idx != IDX_MAX) r_idx <= r_idx + 4'd1;
            r_ws_last <= 1'b0;
            r_state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (w_expired) r_state <= ST_FETCH;
        end
        ST_WSPACE: begin
          if (w_expired) begin
            r_shift   <= {r_shift[WORD_W-3:0], 2'b00};
            if (r_idx != IDX_MAX) r_idx <= r_idx + 4'd1;
            r_ws_last <= 1'b1;
            r_state   <= ST_FETCH;
          end
        end
        ST_CGAP: begin
          if (w_expired) begin
            r_next  <= 1'b1;
            r_state <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// Scoreboard bench for morse_keyer with UNIT_CYCLES=4: the monitor reduces o_key,
// o_next and o_busy to timed events and checks them against queued expectations.
module tb_morse_keyer;

  localparam int U = 4;

  localparam int EV_MARK    = 0;  // o_key high run length
  localparam int EV_GAP     = 1;  // low run between two marks of one character
  localparam int EV_NEXT    = 2;  // low busy cycles before o_next (since last fall or acceptance)
  localparam int EV_BUSYLOW = 3;  // cycles from o_next until o_busy seen low

  typedef struct {
    int kind;
    int len;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic o_key;
  logic o_busy;

  morse_keyer_if bus ();

  morse_keyer #(
    .UNIT_CYCLES (U),
    .CNT_W       (8)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .fifo   (bus),
    .o_key  (o_key),
    .o_busy (o_busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  ev_t        exp_q[$];
  logic [19:0] fifo_q[$];
  logic        drop_mode = 1'b0;
  logic        mon_en    = 1'b1;
  int          next_cnt  = 0;

  function automatic string ev_name(input int k);
    case (k)
      EV_MARK: return "mark";
      EV_GAP:  return "gap";
      EV_NEXT: return "next";
      default: return "busylow";
    endcase
  endfunction

  function automatic void check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  function automatic void expect_ev(input int kind, input int len);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected %s event: got len %0d, expected no event", ev_name(kind), len);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.len != len) begin
        errors++;
        $display("FAIL event: got %s/%0d, expected %s/%0d",
                 ev_name(kind), len, ev_name(e.kind), e.len);
      end
    end
  endfunction

  function automatic void push_ev(input int kind, input int len);
    ev_t e;
    e.kind = kind;
    e.len  = len;
    exp_q.push_back(e);
  endfunction

  // FIFO model: head is visible while non-empty, popped on o_next.
  always @(negedge clk) begin
    if (bus.o_next === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (drop_mode && o_busy === 1'b1) fifo_q.delete();
    bus.i_valid = (fifo_q.size() > 0);
    bus.i_data  = (fifo_q.size() > 0) ? fifo_q[0] : 20'hFFFFF;
  end

  always @(negedge clk) begin
    if (!rst && bus.o_next === 1'b1) next_cnt++;
  end

  int   hi_cnt, lo_cnt, post_cnt;
  logic prev_key, seen_fall, post;

  always @(negedge clk) begin
    if (rst || !mon_en) begin
      hi_cnt    = 0;
      lo_cnt    = 0;
      post_cnt  = 0;
      post      = 1'b0;
      seen_fall = 1'b0;
      prev_key  = o_key;
    end else begin
      if (bus.o_next === 1'b1) begin
        expect_ev(EV_NEXT, lo_cnt);
        lo_cnt    = 0;
        seen_fall = 1'b0;
        post      = 1'b1;
        post_cnt  = 0;
      end else if (post) begin
        post_cnt++;
        if (o_busy !== 1'b1) begin
          expect_ev(EV_BUSYLOW, post_cnt);
          post = 1'b0;
        end
      end else if (o_key === 1'b1) begin
        if (!prev_key && seen_fall) expect_ev(EV_GAP, lo_cnt);
        hi_cnt++;
      end else begin
        if (prev_key) begin
          expect_ev(EV_MARK, hi_cnt);
          hi_cnt    = 0;
          lo_cnt    = 0;
          seen_fall = 1'b1;
        end
        if (o_busy === 1'b1) lo_cnt++;
      end
      prev_key = (o_key === 1'b1);
    end
  end

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_busy !== 1'b0 || fifo_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      vectors++;
      errors++;
      $display("FAIL %s timeout: %0d events still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  // Expected events for one character with the given mark lengths (in cycles).
  // A symbol gap spans GAP (1 unit) plus the FETCH cycle; the final low run is
  // GAP + FETCH + CGAP (2 units).
  task automatic expect_char(input int marks[$]);
    for (int i = 0; i < marks.size(); i++) begin
      if (i > 0) push_ev(EV_GAP, U + 1);
      push_ev(EV_MARK, marks[i]);
    end
    push_ev(EV_NEXT, U + 1 + 2 * U);
    push_ev(EV_BUSYLOW, 2);
  endtask

  initial begin
    int nb, rises, n;
    logic pk;
    int m[$];

    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset o_key", int'(o_key), 0);
    check("reset o_next", int'(bus.o_next), 0);
    check("reset o_busy", int'(o_busy), 0);

    // "E", valid dropped and data scrambled after acceptance
    m = '{U};
    expect_char(m);
    drop_mode = 1'b1;
    fifo_q.push_back(20'h40000);
    wait_done("E", 200);
    drop_mode = 1'b0;

    // "A"
    m = '{U, 3 * U};
    expect_char(m);
    fifo_q.push_back(20'h60000);
    wait_done("A", 300);

    // ten dashes, no terminator
    m = {};
    for (int i = 0; i < 10; i++) m.push_back(3 * U);
    expect_char(m);
    fifo_q.push_back(20'hAAAAA);
    wait_done("full word", 1000);

    // word space then terminator: FETCH + WSPACE(7u) + FETCH, no CGAP
    push_ev(EV_NEXT, 1 + 7 * U + 1);
    push_ev(EV_BUSYLOW, 2);
    fifo_q.push_back(20'hC0000);
    wait_done("word space", 200);

    // all-zero word is skipped straight to ACK
    push_ev(EV_NEXT, 0);
    push_ev(EV_BUSYLOW, 2);
    fifo_q.push_back(20'h00000);
    wait_done("zero word", 50);

    // back-to-back "E" then "T" with i_valid held
    nb = next_cnt;
    m = '{U};
    expect_char(m);
    m = '{3 * U};
    expect_char(m);
    fifo_q.push_back(20'h40000);
    fifo_q.push_back(20'h80000);
    wait_done("back-to-back", 400);
    check("b2b o_next count", next_cnt - nb, 2);

    // reset during the second mark of "A"
    mon_en = 1'b0;
    nb = next_cnt;
    fifo_q.push_back(20'h60000);
    rises = 0;
    n = 0;
    pk = 1'b0;
    while (rises < 2 && n < 200) begin
      @(negedge clk);
      if (o_key === 1'b1 && !pk) rises++;
      pk = (o_key === 1'b1);
      n++;
    end
    check("second mark reached", rises, 2);
    repeat (3) @(negedge clk);
    check("o_key before reset", int'(o_key), 1);
    rst = 1'b1;
    @(negedge clk);
    check("o_key after reset", int'(o_key), 0);
    check("o_busy after reset", int'(o_busy), 0);
    rst = 1'b0;
    check("no o_next for aborted word", next_cnt - nb, 0);
    m = '{U, 3 * U};
    expect_char(m);
    @(posedge clk);
    mon_en = 1'b1;
    wait_done("re-accept after reset", 300);
    check("o_next after re-accept", next_cnt - nb, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
